// File: rtl/mac_pkg.sv
// Shared types and constants for the streaming dot-product engine.
// Pipeline: product register -> tree register -> accumulator.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

    localparam int unsigned PIPE_DEPTH   = 3;
    localparam int unsigned DRAIN_CYCLES = 2;

    // A sum of 'lanes' values of in_w bits needs log2(lanes) extra bits.
    function automatic int unsigned tree_out_w(input int unsigned lanes,
                                               input int unsigned in_w);
        return in_w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/mac_tree_engine_adder_tree.sv
// Balanced combinational reduction of LANES values with one output register.
// Each lane is sign- or zero-extended to the full tree width before summing.
module mac_adder_tree
    import mac_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned IN_W  = 16,
    localparam int unsigned OUT_W = tree_out_w(LANES, IN_W)
) (
    input  logic                  clock,
    input  logic                  reset_l,
    input  logic                  in_valid,
    input  logic                  sign_ext,
    input  logic [LANES*IN_W-1:0] in_data,
    output logic [OUT_W-1:0]      sum,
    output logic                  out_valid
);

    // Heap layout: leaves at LANES-1 .. 2*LANES-2, root at index 0.
    logic [OUT_W-1:0] node [2*LANES-1];
    logic [OUT_W-1:0] sum_d, sum_q;
    logic             valid_d, valid_q;

    always_comb begin
        for (int unsigned i = 0; i < 2*LANES-1; i++) begin
            node[i] = '0;
        end
        for (int unsigned l = 0; l < LANES; l++) begin
            if (sign_ext) begin
                node[LANES-1+l] = OUT_W'($signed(in_data[l*IN_W +: IN_W]));
            end else begin
                node[LANES-1+l] = OUT_W'(in_data[l*IN_W +: IN_W]);
            end
        end
        for (int unsigned k = 0; k < LANES-1; k++) begin
            node[LANES-2-k] = node[2*(LANES-2-k)+1] + node[2*(LANES-2-k)+2];
        end
        sum_d   = in_valid ? node[0] : sum_q;
        valid_d = in_valid;
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/mac_tree_engine.sv
// Streaming dot-product engine: lane multipliers, adder tree, accumulator,
// run-length FSM with start/done handshake, sticky overflow and cycle count.
module mac_tree_engine
    import mac_pkg::*;
#(
    parameter int unsigned LANES  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned LEN_W  = 12
) (
    input  logic                    clock,
    input  logic                    reset_l,
    input  logic                    start,
    input  logic [LEN_W-1:0]        vec_len,
    input  logic                    signed_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] a_data,
    input  logic [LANES*DATA_W-1:0] b_data,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        result,
    output logic                    overflow,
    output logic [15:0]             cycle_count
);

    localparam int unsigned PROD_W = 2*DATA_W;
    localparam int unsigned SUM_W  = tree_out_w(LANES, PROD_W);

    generate
        if (ACC_W < SUM_W) begin : g_acc_w_check
            $error("mac_tree_engine: ACC_W too narrow for tree sum");
        end
        if (LANES < 2 || (LANES & (LANES-1)) != 0) begin : g_lanes_check
            $error("mac_tree_engine: LANES must be a power of two >= 2");
        end
        if (DRAIN_CYCLES != PIPE_DEPTH-1) begin : g_drain_check
            $error("mac_tree_engine: drain length must cover the pipeline");
        end
    endgenerate

    mac_state_t             state_d, state_q;
    logic [LEN_W-1:0]       beat_d, beat_q;
    logic [1:0]             drain_d, drain_q;
    logic                   sm_d, sm_q;
    logic [ACC_W-1:0]       acc_d, acc_q;
    logic                   ovf_d, ovf_q;
    logic [15:0]            cc_d, cc_q;
    logic [LANES*PROD_W-1:0] prod_d, prod_q;
    logic                   pv_d, pv_q;

    logic                   accept;
    logic signed [DATA_W:0] ax, bx;
    logic signed [2*DATA_W+1:0] pfull;
    logic [SUM_W-1:0]       tree_sum;
    logic                   tree_valid;
    logic [ACC_W-1:0]       addend;
    logic [ACC_W-1:0]       acc_sum;
    logic                   acc_carry;
    logic                   ovf_step;

    assign accept = in_valid && (state_q == ST_RUN);

    // One extra operand bit lets one signed multiplier serve both modes.
    always_comb begin
        prod_d = prod_q;
        pv_d   = accept;
        ax     = '0;
        bx     = '0;
        pfull  = '0;
        if (accept) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                ax = {sm_q & a_data[l*DATA_W+DATA_W-1], a_data[l*DATA_W +: DATA_W]};
                bx = {sm_q & b_data[l*DATA_W+DATA_W-1], b_data[l*DATA_W +: DATA_W]};
                pfull = ax * bx;
                prod_d[l*PROD_W +: PROD_W] = pfull[PROD_W-1:0];
            end
        end
    end

    mac_adder_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W)
    ) u_tree (
        .clock     (clock),
        .reset_l   (reset_l),
        .in_valid  (pv_q),
        .sign_ext  (sm_q),
        .in_data   (prod_q),
        .sum       (tree_sum),
        .out_valid (tree_valid)
    );

    always_comb begin
        addend = sm_q ? ACC_W'($signed(tree_sum)) : ACC_W'(tree_sum);
        {acc_carry, acc_sum} = {1'b0, acc_q} + {1'b0, addend};
        if (sm_q) begin
            ovf_step = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                       (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            ovf_step = acc_carry;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        sm_d    = sm_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cc_d    = cc_q;

        if (state_q != ST_IDLE && cc_q != 16'hFFFF) begin
            cc_d = cc_q + 16'd1;
        end
        if (tree_valid) begin
            acc_d = acc_sum;
            if (ovf_step) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cc_d    = '0;
                    sm_d    = signed_mode;
                    beat_d  = vec_len;
                    state_d = (vec_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    beat_d = beat_q - LEN_W'(1);
                    if (beat_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                        drain_d = 2'(DRAIN_CYCLES - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            drain_q <= '0;
            sm_q    <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cc_q    <= '0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            sm_q    <= sm_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cc_q    <= cc_d;
            prod_q  <= prod_d;
            pv_q    <= pv_d;
        end
    end

    assign in_ready    = (state_q == ST_RUN);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign result      = acc_q;
    assign overflow    = ovf_q;
    assign cycle_count = cc_q;

endmodule

// File: tb/tb_mac_tree_engine.sv
// Directed bench for mac_tree_engine: a 32-bit and a 19-bit accumulator
// instance share one input stream; expected values are hand-computed.
module tb_mac_tree_engine;

    logic        clock;
    logic        reset_l;
    logic        start;
    logic [11:0] vec_len;
    logic        signed_mode;
    logic        in_valid;
    logic [63:0] a_data;
    logic [63:0] b_data;

    logic        in_ready, busy, done, overflow;
    logic [31:0] result;
    logic [15:0] cycle_count;

    logic        in_ready19, busy19, done19, overflow19;
    logic [18:0] result19;
    logic [15:0] cycle_count19;

    int total = 0;
    int bad   = 0;
    int n;
    int seen_done;

    mac_tree_engine #(.LANES(8), .DATA_W(8), .ACC_W(32), .LEN_W(12)) u_dut (
        .clock       (clock),
        .reset_l     (reset_l),
        .start       (start),
        .vec_len     (vec_len),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_data      (a_data),
        .b_data      (b_data),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .cycle_count (cycle_count)
    );

    mac_tree_engine #(.LANES(8), .DATA_W(8), .ACC_W(19), .LEN_W(12)) u_dut19 (
        .clock       (clock),
        .reset_l     (reset_l),
        .start       (start),
        .vec_len     (vec_len),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready19),
        .a_data      (a_data),
        .b_data      (b_data),
        .busy        (busy19),
        .done        (done19),
        .result      (result19),
        .overflow    (overflow19),
        .cycle_count (cycle_count19)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [11:0] len, input logic sm);
        start       = 1'b1;
        vec_len     = len;
        signed_mode = sm;
        tick();
        start       = 1'b0;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        a_data   = {8{a}};
        b_data   = {8{b}};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset_l     = 1'b0;
        start       = 1'b0;
        vec_len     = '0;
        signed_mode = 1'b0;
        in_valid    = 1'b0;
        a_data      = '0;
        b_data      = '0;
        tick();
        tick();
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_cc", cycle_count, 0);
        check("rst_busy19", busy19, 0);
        reset_l = 1'b1;
        tick();

        // unsigned, no stalls: 2 beats of 8 lanes * 1*2
        do_start(12'd2, 1'b0);
        check("u_busy_s1", busy, 1);
        check("u_ready_s1", in_ready, 1);
        beat(8'd1, 8'd2);
        beat(8'd1, 8'd2);
        check("u_ready_drain", in_ready, 0);
        wait_done(n);
        check("u_done_lat", n, 2);
        check("u_result", result, 32);
        check("u_ovf", overflow, 0);
        tick();
        check("u_cc", cycle_count, 5);
        check("u_done_pulse", done, 0);
        check("u_busy_end", busy, 0);

        // signed: 8 * (-1 * 3) = -24
        do_start(12'd1, 1'b1);
        beat(8'hFF, 8'd3);
        wait_done(n);
        check("s_done_lat", n, 2);
        check("s_result", result, 32'hFFFF_FFE8);
        tick();

        // unsigned: 8 * 255 * 3; mode change after start must not matter
        do_start(12'd1, 1'b0);
        signed_mode = 1'b1;
        beat(8'hFF, 8'd3);
        wait_done(n);
        check("us_result", result, 6120);
        tick();
        signed_mode = 1'b0;

        // stalls plus an ignored start during RUN
        do_start(12'd3, 1'b0);
        beat(8'd1, 8'd1);
        start   = 1'b1;
        vec_len = 12'd0;
        tick();
        start   = 1'b0;
        check("st_busy", busy, 1);
        check("st_ready", in_ready, 1);
        tick();
        beat(8'd1, 8'd1);
        beat(8'd1, 8'd1);
        wait_done(n);
        check("st_done_lat", n, 2);
        check("st_result", result, 24);
        tick();
        check("st_cc", cycle_count, 8);

        // reset mid-run: accumulator already holds 32 when reset hits
        do_start(12'd4, 1'b0);
        beat(8'd2, 8'd2);
        beat(8'd2, 8'd2);
        tick();
        check("mr_acc_pre", result, 32);
        reset_l = 1'b0;
        tick();
        tick();
        check("mr_result", result, 0);
        check("mr_ovf", overflow, 0);
        check("mr_cc", cycle_count, 0);
        check("mr_busy", busy, 0);
        check("mr_ready", in_ready, 0);
        reset_l   = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1;
        end
        check("mr_no_done", seen_done, 0);
        check("mr_busy_after", busy, 0);

        // overflow: 2 * 8 * 65025 = 1040400; mod 2^19 = 516112
        do_start(12'd2, 1'b0);
        beat(8'hFF, 8'hFF);
        beat(8'hFF, 8'hFF);
        wait_done(n);
        check("ov_done_lat", n, 2);
        check("ov_result19", result19, 516112);
        check("ov_flag19", overflow19, 1);
        check("ov_done19", done19, 1);
        check("ov_result32", result, 1040400);
        check("ov_flag32", overflow, 0);
        tick();

        // zero length; also clears the sticky overflow
        do_start(12'd0, 1'b0);
        check("z_done", done, 1);
        check("z_ready", in_ready, 0);
        check("z_result", result, 0);
        check("z_ovf19_clr", overflow19, 0);
        check("z_result19", result19, 0);
        tick();
        check("z_cc", cycle_count, 1);
        check("z_cc19", cycle_count19, 1);
        check("z_done_off", done, 0);
        check("z_ready19", in_ready19, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_tree_engine.md
# mac_tree_engine

Parametrised streaming dot-product engine: accepts LANES element pairs per beat over a valid/ready stream, multiplies them lane-wise, reduces the products in an adder tree and accumulates over a run of beats. It reports the result, a sticky overflow flag and the run's cycle count. It is the reusable core behind the matrix-multiply datapath, sitting between the operand ROM/address sequencers and the result/cycle-count display registers. Against the fixed 64-wide flow it adds run-time length, signed/unsigned mode, stall tolerance, a start/done handshake and overflow detection.

## Interface
- LANES, 8, element pairs per beat; power of two, ≥ 2
- DATA_W, 8, operand width
- ACC_W, 32, accumulator/result width; must be ≥ 2*DATA_W + log2(LANES) (elaboration error otherwise)
- LEN_W, 12, width of vec_len (beats per run)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset_l  in  1  synchronous, active-low reset
- start  in  1  begin run; sampled only in IDLE
- vec_len  in  LEN_W  beats in run; sampled with start
- signed_mode  in  1  1 = two's-complement operands; sampled with start, held for run
- in_valid  in  1  beat present
- in_ready  out  1  engine accepts beat
- a_data, b_data  in  LANES×DATA_W  operand vectors, lane 0 in LSBs
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, result final
- result  out  ACC_W  accumulated sum; held until next accepted start
- overflow  out  1  sticky; set if any accumulate overflowed in this run
- cycle_count  out  16  cycles in RUN+DRAIN+DONE of last/current run, saturates at 0xFFFF

## Operation
- FSM states IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. start=1 with vec_len≠0 → RUN; accumulator, overflow and cycle_count clear, beat counter loads vec_len. start=1 with vec_len=0 → DONE directly, result=0.
- RUN: in_ready=1. Beat accepted when in_valid&in_ready; beat counter decrements. Acceptance of last beat → DRAIN. in_valid low inserts a bubble: stage-valid bit 0, accumulator unchanged.
- DRAIN: in_ready=0, exactly 2 cycles, → DONE.
- DONE: done=1 for one cycle, → IDLE. start ignored in RUN/DRAIN/DONE.
- Arithmetic: lane products 2*DATA_W bits, signed or unsigned per signed_mode. Tree sum widened by log2(LANES), sign/zero-extended to ACC_W. Accumulator wraps modulo 2^ACC_W.
- Overflow detection: unsigned uses carry-out; signed uses operands of same sign giving a result of different sign.
- cycle_count increments every cycle in RUN, DRAIN and DONE, and holds in IDLE.
- Reset at any time: state IDLE. All outputs 0, including result, overflow, cycle_count, done and busy. Pipeline valid bits clear. No done for an aborted run.

## Timing
- Beat accepted in cycle c → product registers at end of c → tree-sum register at end of c+1 → accumulator at end of c+2.
- Last beat in cycle L: DRAIN in L+1..L+2, done=1 and result final in L+3.
- Cycle count for a run with no stalls is vec_len+3; each stall cycle adds 1.
- start in cycle S → busy=1 from S+1 and first in_ready=1 in S+1.
- vec_len=0: done in S+1, cycle_count=1.

## Structure
- Package mac_pkg holds:
  - state enum mac_state_t
  - constant PIPE_DEPTH=3
  - constant DRAIN_CYCLES=2
  - function for tree output width
- Sub-module mac_adder_tree (LANES, IN_W):
  - combinational balanced reduction with a single output register and valid bit
  - instanced once
- Multipliers are inferred inside mac_tree_engine, one per lane, with a shared stage-valid bit.

## Test plan
All scenarios use LANES=8, DATA_W=8, ACC_W=32 unless stated.
- Reset: hold reset_l=0 for 2 cycles mid-run → result=0, overflow=0, cycle_count=0, busy=0, in_ready=0; no done afterwards.
- Unsigned, no stalls: vec_len=2, all a=1, b=2 → result=32, done 3 cycles after last beat, cycle_count=5, overflow=0.
- Signed vs unsigned: vec_len=1, all a=0xFF, b=3.
  - signed_mode=1 → result=0xFFFFFFE8 (−24)
  - signed_mode=0 → result=6120
- Stalls: vec_len=3, in_valid low for 2 cycles between beats, all a=b=1 → result=24, cycle_count=8. Also, start pulsed during RUN is ignored.
- Overflow (ACC_W=19), unsigned, vec_len=2, a=b=255 → result=516112, overflow=1. A subsequent start clears overflow.
- Zero length: start with vec_len=0 → done in next cycle, result=0, cycle_count=1, in_ready never 1.
